// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: two-flop synchronisers, per-channel debounce,
// and an INIT/RUN decoder that turns filtered Gray-code transitions into a
// registered step pulse, a held direction flag, a wrapping position count,
// a wrap carry and a sticky illegal-transition flag.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_INIT | track raw synced levels until both are stable DEBOUNCE cycles,
//        | then adopt them as the filtered reference without any event
// S_RUN  | debounce each channel; decode every filtered change
module quad_step_decoder #(
    parameter int WIDTH    = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] pos,
    output logic             rc,
    output logic             err
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state_q, state_d;
    logic             a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic             fa_q, fa_d, fb_q, fb_d;
    logic [CW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [CW-1:0]    init_cnt_q, init_cnt_d;
    logic             step_q, step_d, dir_q, dir_d, rc_q, rc_d, err_q, err_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             a_acc, b_acc, fwd;

    // Position of a 2-bit code along the forward sequence 00->01->11->10.
    function automatic logic [1:0] gray_idx(input logic [1:0] code);
        case (code)
            2'b00:   gray_idx = 2'd0;
            2'b01:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    // Two-flop synchronisers for the asynchronous encoder pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_q <= 1'b0;
            a_s2_q <= 1'b0;
            b_s1_q <= 1'b0;
            b_s2_q <= 1'b0;
        end else begin
            a_s1_q <= a_in;
            a_s2_q <= a_s1_q;
            b_s1_q <= b_in;
            b_s2_q <= b_s1_q;
        end
    end

    // Per-channel debounce: count consecutive cycles the synced level differs
    // from the filtered one; accept on the DEBOUNCE-th. Held idle during INIT.
    always_comb begin
        cnt_a_d = '0;
        cnt_b_d = '0;
        a_acc   = 1'b0;
        b_acc   = 1'b0;
        if (state_q == S_RUN) begin
            if (a_s2_q != fa_q) begin
                if (cnt_a_q == DB_MAX) a_acc = 1'b1;
                else                   cnt_a_d = cnt_a_q + 1'b1;
            end
            if (b_s2_q != fb_q) begin
                if (cnt_b_q == DB_MAX) b_acc = 1'b1;
                else                   cnt_b_d = cnt_b_q + 1'b1;
            end
        end
    end

    // Next-state and output decode; the step is registered on the same edge
    // the filtered level changes so latency stays at DEBOUNCE+2 edges.
    always_comb begin
        state_d    = state_q;
        fa_d       = fa_q;
        fb_d       = fb_q;
        init_cnt_d = '0;
        step_d     = 1'b0;
        rc_d       = 1'b0;
        dir_d      = dir_q;
        err_d      = err_q;
        pos_d      = pos_q;
        fwd        = 1'b0;
        case (state_q)
            S_INIT: begin
                if ({a_s2_q, b_s2_q} != {fa_q, fb_q}) begin
                    fa_d = a_s2_q;
                    fb_d = b_s2_q;
                end else if (init_cnt_q == DB_MAX) begin
                    state_d = S_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            default: begin
                if (a_acc) fa_d = a_s2_q;
                if (b_acc) fb_d = b_s2_q;
                if (a_acc && b_acc) begin
                    // Both bits moved at once: direction unknown, just
                    // resynchronise the reference and flag it.
                    err_d = 1'b1;
                end else if (a_acc || b_acc) begin
                    fwd   = (gray_idx({fa_d, fb_d}) == gray_idx({fa_q, fb_q}) + 2'd1);
                    dir_d = fwd;
                    if (!clr) begin
                        step_d = 1'b1;
                        pos_d  = fwd ? pos_q + 1'b1 : pos_q - 1'b1;
                        rc_d   = fwd ? (&pos_q) : ~(|pos_q);
                    end
                end
            end
        endcase
        if (clr) begin
            pos_d = '0;
            err_d = 1'b0;
        end
    end

    // State register for the filter, decoder and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            fa_q       <= 1'b0;
            fb_q       <= 1'b0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            init_cnt_q <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            rc_q       <= 1'b0;
            err_q      <= 1'b0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            fa_q       <= fa_d;
            fb_q       <= fb_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            init_cnt_q <= init_cnt_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            rc_q       <= rc_d;
            err_q      <= err_d;
            pos_q      <= pos_d;
        end
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign rc   = rc_q;
    assign err  = err_q;
    assign pos  = pos_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus a random walk of
// encoder moves compared with a phase-index model of the encoder.
module tb_quad_step_decoder;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk, rst_n, a_in, b_in, clr;
    logic         step, dir, rc, err;
    logic [W-1:0] pos;

    quad_step_decoder #(.WIDTH(W), .DEBOUNCE(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_in  (a_in),
        .b_in  (b_in),
        .clr   (clr),
        .step  (step),
        .dir   (dir),
        .pos   (pos),
        .rc    (rc),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Encoder model: phase counts detents along 00,01,11,10; pos/dir/err follow.
    int           phase = 0;
    logic [W-1:0] m_pos = '0;
    logic         m_dir = 1'b0;
    logic         m_err = 1'b0;
    int           m_steps = 0;
    int           m_rcs = 0;

    // Pulse monitor, sampled on the falling edge.
    int   steps_seen = 0, rcs_seen = 0, dbl_seen = 0, orphan_rc = 0;
    logic step_prev = 1'b0;
    always @(negedge clk) begin
        if (step) steps_seen++;
        if (rc) rcs_seen++;
        if (step && step_prev) dbl_seen++;
        if (rc && !step) orphan_rc++;
        step_prev = step;
    end

    function automatic logic [1:0] code_of(input int p);
        logic [1:0] tbl [4];
        tbl = '{2'b00, 2'b01, 2'b11, 2'b10};
        return tbl[((p % 4) + 4) % 4];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_code(input logic [1:0] c);
        a_in = c[1];
        b_in = c[0];
    endtask

    // One encoder move of delta detents (+-1 legal, +-2 illegal), then hold.
    task automatic move(input int delta, input int hold);
        phase = phase + delta;
        if (delta == 1 || delta == -1) begin
            if ((delta == 1 && m_pos == '1) || (delta == -1 && m_pos == '0)) m_rcs++;
            m_pos = (delta == 1) ? m_pos + 1'b1 : m_pos - 1'b1;
            m_dir = (delta == 1);
            m_steps++;
        end else begin
            m_err = 1'b1;
        end
        drive_code(code_of(phase));
        tick(hold);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_pos = '0;
        m_err = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr = 1'b0;
        drive_code(2'b00);
        tick(3);
        checks++;
        if ({step, dir, rc, err, pos} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h required 0", {step, dir, rc, err, pos});
        end
        rst_n = 1'b1;
        tick(20);
        checks++;
        if (steps_seen !== 0) begin
            errors++;
            $display("FAIL init_no_step: got %0d steps required 0", steps_seen);
        end
        checks++;
        if (pos !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL init_pos_err: got pos=%0h err=%0b required 0/0", pos, err);
        end
    endtask

    task automatic test_forward();
        int s0, lat;
        s0 = steps_seen;
        for (int i = 0; i < 4; i++) begin
            phase = phase + 1;
            m_pos = m_pos + 1'b1;
            m_dir = 1'b1;
            m_steps++;
            drive_code(code_of(phase));
            lat = 0;
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk);
                #1;
                if (step && lat == 0) lat = k;
            end
            checks++;
            if (lat !== 6) begin
                errors++;
                $display("FAIL step_latency: got %0d edges required 6 (move %0d)", lat, i);
            end
        end
        checks++;
        if (steps_seen - s0 !== 4) begin
            errors++;
            $display("FAIL fwd_step_count: got %0d required 4", steps_seen - s0);
        end
        checks++;
        if (pos !== m_pos || dir !== 1'b1) begin
            errors++;
            $display("FAIL fwd_pos_dir: got pos=%0h dir=%0b required %0h/1", pos, dir, m_pos);
        end
    endtask

    task automatic test_wrap();
        int r0;
        pulse_clr();
        checks++;
        if (pos !== '0) begin
            errors++;
            $display("FAIL clr_pos: got %0h required 0", pos);
        end
        r0 = rcs_seen;
        move(-1, 10);
        checks++;
        if (pos !== 16'hFFFF || dir !== 1'b0 || rcs_seen - r0 !== 1) begin
            errors++;
            $display("FAIL wrap_down: got pos=%0h dir=%0b rc=%0d required ffff/0/1",
                     pos, dir, rcs_seen - r0);
        end
        move(1, 10);
        checks++;
        if (pos !== 16'h0000 || dir !== 1'b1 || rcs_seen - r0 !== 2) begin
            errors++;
            $display("FAIL wrap_up: got pos=%0h dir=%0b rc=%0d required 0/1/2",
                     pos, dir, rcs_seen - r0);
        end
    endtask

    task automatic test_glitch();
        int s0;
        s0 = steps_seen;
        a_in = ~a_in;
        tick(3);
        a_in = ~a_in;
        tick(10);
        checks++;
        if (steps_seen !== s0 || pos !== m_pos || err !== m_err) begin
            errors++;
            $display("FAIL glitch: got steps=%0d pos=%0h err=%0b required %0d/%0h/%0b",
                     steps_seen - s0, pos, err, 0, m_pos, m_err);
        end
    endtask

    task automatic test_error_clear();
        logic [W-1:0] p0;
        logic         d0;
        p0 = pos;
        d0 = dir;
        move(2, 10);
        checks++;
        if (err !== 1'b1 || pos !== p0 || dir !== d0) begin
            errors++;
            $display("FAIL illegal: got err=%0b pos=%0h dir=%0b required 1/%0h/%0b", err, pos, dir, p0, d0);
        end
        pulse_clr();
        checks++;
        if (err !== 1'b0 || pos !== '0) begin
            errors++;
            $display("FAIL clr_err: got err=%0b pos=%0h required 0/0", err, pos);
        end
        move(1, 10);
        move(1, 10);
        checks++;
        if (pos !== 16'd2 || dir !== 1'b1) begin
            errors++;
            $display("FAIL count_after_clr: got pos=%0h dir=%0b required 2/1", pos, dir);
        end
    endtask

    task automatic test_random();
        int r, len, s0, rc0;
        logic [1:0] c;
        pulse_clr();
        s0 = steps_seen;
        rc0 = rcs_seen;
        m_steps = 0;
        m_rcs = 0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                move(1, $urandom_range(8, 14));
            end else if (r < 8) begin
                move(-1, $urandom_range(8, 14));
            end else if (r == 8) begin
                len = $urandom_range(1, D - 1);
                c = code_of(phase);
                if ($urandom_range(0, 1) == 1) drive_code(c ^ 2'b10);
                else                          drive_code(c ^ 2'b01);
                tick(len);
                drive_code(c);
                tick(8);
            end else begin
                move(($urandom_range(0, 1) == 1) ? 2 : -2, 10);
            end
            checks++;
            if (pos !== m_pos || dir !== m_dir || err !== m_err) begin
                errors++;
                $display("FAIL random_%0d: got pos=%0h dir=%0b err=%0b required %0h/%0b/%0b",
                         i, pos, dir, err, m_pos, m_dir, m_err);
            end
        end
        checks++;
        if (steps_seen - s0 !== m_steps || rcs_seen - rc0 !== m_rcs) begin
            errors++;
            $display("FAIL random_pulses: got steps=%0d rc=%0d required %0d/%0d",
                     steps_seen - s0, rcs_seen - rc0, m_steps, m_rcs);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        if (code_of(phase + 5) == 2'b11) move(1, 10);
        pulse_clr();
        for (int i = 0; i < 5; i++) move(1, 10);
        checks++;
        if (pos !== 16'd5) begin
            errors++;
            $display("FAIL pre_reset_pos: got %0h required 5", pos);
        end
        drive_code(2'b11);
        tick(2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({step, dir, rc, err, pos} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %0h required 0", {step, dir, rc, err, pos});
        end
        tick(3);
        rst_n = 1'b1;
        phase = 2;
        m_pos = '0;
        m_dir = 1'b0;
        m_err = 1'b0;
        s0 = steps_seen;
        tick(20);
        checks++;
        if (steps_seen !== s0 || err !== 1'b0 || pos !== '0) begin
            errors++;
            $display("FAIL init_11: got steps=%0d err=%0b pos=%0h required 0/0/0",
                     steps_seen - s0, err, pos);
        end
        move(1, 10);
        checks++;
        if (pos !== 16'd1 || dir !== 1'b1) begin
            errors++;
            $display("FAIL after_init_11: got pos=%0h dir=%0b required 1/1", pos, dir);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        a_in = 1'b0;
        b_in = 1'b0;
        #1;
        test_reset();
        test_forward();
        test_wrap();
        test_glitch();
        test_error_clear();
        test_random();
        test_reset_mid();
        checks++;
        if (dbl_seen !== 0 || orphan_rc !== 0) begin
            errors++;
            $display("FAIL pulse_shape: got double=%0d orphan_rc=%0d required 0/0", dbl_seen, orphan_rc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
